dram_ctrl_openrow: RTL and testbench

//  Parametrised open-page DRAM command controller; successor to dram_ctrl. Takes decoded

---
 rtl/dram_ctrl_openrow.sv | 265 ++++++++++++++++++++++++++
 tb/tb_dram_ctrl_openrow.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl_openrow.sv
// Open-page DRAM command controller: per-bank open-row tracking, ACT/RD/WR/PRE issue
// under programmable timing, and periodic PREA/REF refresh.
//
// state     | meaning
// S_IDLE    | ready for a request or a pending refresh
// S_PRE     | PRE issued, waiting T_RP before ACT
// S_ACT     | ACT issued, waiting T_RCD before RD/WR
// S_ACCESS  | RD or WR on the bus this cycle
// S_RD_WAIT | waiting T_CL for read data
// S_PREA    | PREA issued, waiting T_RP before REF
// S_REF     | REF issued, waiting T_RFC before IDLE
module dram_ctrl_openrow #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int T_CL         = 2,
    parameter int T_RFC        = 4,
    parameter int REFI         = 64,
    localparam int BANK_W      = $clog2(NUM_OF_BANKS),
    localparam int ROW_W       = $clog2(NUM_OF_ROWS),
    localparam int COL_W       = $clog2(NUM_OF_COLS),
    localparam int ADDR_W      = BANK_W + ROW_W + COL_W
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [2:0]              cmd,
    output logic [BANK_W-1:0]       cmd_bank,
    output logic [ROW_W-1:0]        cmd_row,
    output logic [COL_W-1:0]        cmd_col,
    output logic [DATA_WIDTH-1:0]   dram_wdata,
    input  logic [DATA_WIDTH-1:0]   dram_rdata,
    output logic [NUM_OF_BANKS-1:0] open_bank_mask
);

    localparam int T_A   = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int T_B   = (T_CL > T_RFC) ? T_CL : T_RFC;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam int REF_W = $clog2(REFI);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ACT, S_ACCESS, S_RD_WAIT, S_PREA, S_REF
    } state_t;

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [REF_W-1:0]                     ref_cnt_q, ref_cnt_d;
    logic                                 ref_pending_q, ref_pending_d;
    logic [BANK_W-1:0]                    bank_q, bank_d;
    logic [ROW_W-1:0]                     row_q, row_d;
    logic [COL_W-1:0]                     col_q, col_d;
    logic                                 wr_q, wr_d;
    logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
    logic [NUM_OF_BANKS-1:0]              open_q, open_d;
    logic [NUM_OF_BANKS-1:0][ROW_W-1:0]   open_row_q, open_row_d;
    logic                                 req_ready_q, req_ready_d;
    logic                                 rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]                rsp_rdata_q, rsp_rdata_d;
    logic [2:0]                           cmd_q, cmd_d;
    logic [BANK_W-1:0]                    cmd_bank_q, cmd_bank_d;
    logic [ROW_W-1:0]                     cmd_row_q, cmd_row_d;
    logic [COL_W-1:0]                     cmd_col_q, cmd_col_d;
    logic [DATA_WIDTH-1:0]                dram_wdata_q, dram_wdata_d;

    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  req_col;
    logic              ref_exp;

    assign req_bank = req_addr[ADDR_W-1 -: BANK_W];
    assign req_row  = req_addr[COL_W +: ROW_W];
    assign req_col  = req_addr[COL_W-1:0];
    assign ref_exp  = (ref_cnt_q == REF_W'(REFI - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        ref_cnt_d     = ref_exp ? '0 : ref_cnt_q + 1'b1;
        ref_pending_d = ref_pending_q | ref_exp;
        bank_d        = bank_q;
        row_d         = row_q;
        col_d         = col_q;
        wr_d          = wr_q;
        wdata_d       = wdata_q;
        open_d        = open_q;
        open_row_d    = open_row_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        cmd_d         = CMD_NOP;
        cmd_bank_d    = '0;
        cmd_row_d     = '0;
        cmd_col_d     = '0;
        dram_wdata_d  = '0;

        case (state_q)
            S_IDLE: begin
                // Refresh outranks a request presented in the same cycle.
                if (ref_pending_q) begin
                    if (|open_q) begin
                        cmd_d   = CMD_PREA;
                        open_d  = '0;
                        cnt_d   = CNT_W'(T_RP - 1);
                        state_d = S_PREA;
                    end else begin
                        cmd_d         = CMD_REF;
                        ref_pending_d = ref_exp;
                        cnt_d         = CNT_W'(T_RFC - 1);
                        state_d       = S_REF;
                    end
                end else if (req_valid && req_ready_q) begin
                    bank_d  = req_bank;
                    row_d   = req_row;
                    col_d   = req_col;
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    if (open_q[req_bank] && open_row_q[req_bank] == req_row) begin
                        cmd_d        = req_wr ? CMD_WR : CMD_RD;
                        cmd_bank_d   = req_bank;
                        cmd_col_d    = req_col;
                        dram_wdata_d = req_wr ? req_wdata : '0;
                        state_d      = S_ACCESS;
                    end else if (open_q[req_bank]) begin
                        cmd_d            = CMD_PRE;
                        cmd_bank_d       = req_bank;
                        open_d[req_bank] = 1'b0;
                        cnt_d            = CNT_W'(T_RP - 1);
                        state_d          = S_PRE;
                    end else begin
                        cmd_d                = CMD_ACT;
                        cmd_bank_d           = req_bank;
                        cmd_row_d            = req_row;
                        open_d[req_bank]     = 1'b1;
                        open_row_d[req_bank] = req_row;
                        cnt_d                = CNT_W'(T_RCD - 1);
                        state_d              = S_ACT;
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    cmd_d              = CMD_ACT;
                    cmd_bank_d         = bank_q;
                    cmd_row_d          = row_q;
                    open_d[bank_q]     = 1'b1;
                    open_row_d[bank_q] = row_q;
                    cnt_d              = CNT_W'(T_RCD - 1);
                    state_d            = S_ACT;
                end
            end
            S_ACT: begin
                if (cnt_q == '0) begin
                    cmd_d        = wr_q ? CMD_WR : CMD_RD;
                    cmd_bank_d   = bank_q;
                    cmd_col_d    = col_q;
                    dram_wdata_d = wr_q ? wdata_q : '0;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wr_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CNT_W'(T_CL - 1);
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = dram_rdata;
                    state_d     = S_IDLE;
                end
            end
            S_PREA: begin
                if (cnt_q == '0) begin
                    cmd_d         = CMD_REF;
                    ref_pending_d = ref_exp;
                    cnt_d         = CNT_W'(T_RFC - 1);
                    state_d       = S_REF;
                end
            end
            S_REF: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE) && !ref_pending_d;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            bank_q        <= '0;
            row_q         <= '0;
            col_q         <= '0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            open_q        <= '0;
            open_row_q    <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            cmd_q         <= CMD_NOP;
            cmd_bank_q    <= '0;
            cmd_row_q     <= '0;
            cmd_col_q     <= '0;
            dram_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            bank_q        <= bank_d;
            row_q         <= row_d;
            col_q         <= col_d;
            wr_q          <= wr_d;
            wdata_q       <= wdata_d;
            open_q        <= open_d;
            open_row_q    <= open_row_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            cmd_q         <= cmd_d;
            cmd_bank_q    <= cmd_bank_d;
            cmd_row_q     <= cmd_row_d;
            cmd_col_q     <= cmd_col_d;
            dram_wdata_q  <= dram_wdata_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign cmd            = cmd_q;
    assign cmd_bank       = cmd_bank_q;
    assign cmd_row        = cmd_row_q;
    assign cmd_col        = cmd_col_q;
    assign dram_wdata     = dram_wdata_q;
    assign open_bank_mask = open_q;

endmodule

// File: tb/tb_dram_ctrl_openrow.sv
// Bench for dram_ctrl_openrow: expected commands and responses are queued at request
// time and popped by a monitor thread whenever the controller drives a command or response.
module tb_dram_ctrl_openrow;

    localparam int BANK_W = 3;
    localparam int ROW_W  = 7;
    localparam int COL_W  = 3;
    localparam int T_CL   = 2;

    localparam logic [2:0] ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, PREA = 3'd5, REF = 3'd6;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [12:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [2:0]  cmd;
    logic [2:0]  cmd_bank;
    logic [6:0]  cmd_row;
    logic [2:0]  cmd_col;
    logic [7:0]  dram_wdata;
    logic [7:0]  dram_rdata;
    logic [7:0]  open_bank_mask;

    dram_ctrl_openrow dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .cmd(cmd), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
        .open_bank_mask(open_bank_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] cmd;
        logic [2:0] bank;
        logic [6:0] row;
        logic [2:0] col;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } rsp_t;

    cmd_t       exp_cmd_q[$];
    rsp_t       exp_rsp_q[$];
    logic [7:0] rd_data_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_cmd(input int c, input logic [2:0] k, input logic [2:0] b,
                            input logic [6:0] r, input logic [2:0] cl, input logic [7:0] wd);
        cmd_t e;
        e.cyc = c; e.cmd = k; e.bank = b; e.row = r; e.col = cl; e.wdata = wd;
        exp_cmd_q.push_back(e);
    endtask

    task automatic push_rsp(input int c, input logic [7:0] d);
        rsp_t e;
        e.cyc = c; e.data = d;
        exp_rsp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Returns just after the clock edge that completes the handshake; t is the handshake cycle.
    task automatic do_req(input logic wr, input logic [2:0] b, input logic [6:0] r,
                          input logic [2:0] cl, input logic [7:0] wd, input logic [7:0] rd,
                          output int t);
        logic got;
        got = 1'b0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = {b, r, cl};
        req_wdata = wd;
        for (int n = 0; n < 400; n++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_timeout: req_ready stayed 0, needed 1 (cycle %0d)", cyc);
            t = -1;
            req_valid = 1'b0;
        end else begin
            t = cyc;
            if (!wr) rd_data_q.push_back(rd);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    int rd_due = -1;
    logic [7:0] rd_val = 8'h00;

    initial begin
        int t, c0, c1;
        cmd_t e;
        rsp_t rs;
        logic ok;

        rst_b = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        dram_rdata = 8'h00;

        fork
            // Monitor: compares every command and response the controller presents.
            forever begin
                @(negedge clk);
                if (rst_b && cmd != 3'd0) begin
                    n_cmp++;
                    if (exp_cmd_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL cmd_unexpected: got cmd %0d at cycle %0d, needed none", cmd, cyc);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        ok = (e.cyc == cyc) && (cmd == e.cmd);
                        if (e.cmd != PREA && e.cmd != REF) ok = ok && (cmd_bank == e.bank);
                        if (e.cmd == ACT) ok = ok && (cmd_row == e.row);
                        if (e.cmd == RD || e.cmd == WR) ok = ok && (cmd_col == e.col);
                        if (e.cmd == WR) ok = ok && (dram_wdata == e.wdata);
                        if (!ok) begin
                            n_bad++;
                            $display("FAIL cmd_check: got cmd=%0d bank=%0d row=%0d col=%0d wdata=%0h cyc=%0d, expected cmd=%0d bank=%0d row=%0d col=%0d wdata=%0h cyc=%0d",
                                     cmd, cmd_bank, cmd_row, cmd_col, dram_wdata, cyc,
                                     e.cmd, e.bank, e.row, e.col, e.wdata, e.cyc);
                        end
                    end
                end
                if (rst_b && rsp_valid) begin
                    n_cmp++;
                    if (exp_rsp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL rsp_unexpected: got rsp_valid data %0h at cycle %0d, needed none", rsp_rdata, cyc);
                    end else begin
                        rs = exp_rsp_q.pop_front();
                        if (rs.cyc != cyc || rs.data != rsp_rdata) begin
                            n_bad++;
                            $display("FAIL rsp_check: got data %0h at cycle %0d, expected %0h at cycle %0d",
                                     rsp_rdata, cyc, rs.data, rs.cyc);
                        end
                    end
                end
            end
            // DRAM array: valid read data only in cycle RD+T_CL, filler otherwise.
            forever begin
                @(negedge clk);
                if (rst_b && cmd == RD) begin
                    rd_due = cyc + T_CL;
                    rd_val = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 8'hFF;
                end
                dram_rdata = (cyc == rd_due) ? rd_val : 8'(cyc ^ 32'h5C);
            end
            begin
                repeat (3) @(negedge clk);
                check("reset_cmd", cmd, 0);
                check("reset_mask", open_bank_mask, 0);
                check("reset_ready", req_ready, 0);
                check("reset_rsp_valid", rsp_valid, 0);
                rst_b = 1'b1;
                c0 = cyc;

                // Read to a closed bank: ACT, RD two cycles later, data three after.
                do_req(1'b0, 3'd2, 7'd5, 3'd3, 8'h00, 8'hA5, t);
                check("t1_accept_cycle", t, c0 + 1);
                push_cmd(t + 1, ACT, 3'd2, 7'd5, 3'd0, 8'h00);
                push_cmd(t + 3, RD, 3'd2, 7'd0, 3'd3, 8'h00);
                push_rsp(t + 6, 8'hA5);
                wait_until(t + 2);
                check("t1_mask", open_bank_mask, 8'h04);

                // Row hit.
                do_req(1'b0, 3'd2, 7'd5, 3'd4, 8'h00, 8'h6B, t);
                check("t2_accept_cycle", t, c0 + 7);
                push_cmd(t + 1, RD, 3'd2, 7'd0, 3'd4, 8'h00);
                push_rsp(t + 4, 8'h6B);

                // Row conflict write.
                do_req(1'b1, 3'd2, 7'd9, 3'd1, 8'h3C, 8'h00, t);
                check("t3_accept_cycle", t, c0 + 11);
                push_cmd(t + 1, PRE, 3'd2, 7'd0, 3'd0, 8'h00);
                push_cmd(t + 3, ACT, 3'd2, 7'd9, 3'd0, 8'h00);
                push_cmd(t + 5, WR, 3'd2, 7'd0, 3'd1, 8'h3C);
                wait_until(t + 2);
                check("t3_mask_after_pre", open_bank_mask, 8'h00);

                // Open bank 5, then idle into the first refresh at c0+63.
                do_req(1'b0, 3'd5, 7'd7, 3'd0, 8'h00, 8'h5A, t);
                check("t4_accept_cycle", t, c0 + 17);
                push_cmd(t + 1, ACT, 3'd5, 7'd7, 3'd0, 8'h00);
                push_cmd(t + 3, RD, 3'd5, 7'd0, 3'd0, 8'h00);
                push_rsp(t + 6, 8'h5A);
                wait_until(c0 + 30);
                push_cmd(c0 + 65, PREA, 3'd0, 7'd0, 3'd0, 8'h00);
                push_cmd(c0 + 67, REF, 3'd0, 7'd0, 3'd0, 8'h00);
                wait_until(c0 + 63);
                check("t4_ready_before_expiry", req_ready, 1);
                wait_until(c0 + 64);
                check("t4_ready_pending", req_ready, 0);
                check("t4_mask_open", open_bank_mask, 8'h24);
                wait_until(c0 + 66);
                check("t4_mask_after_prea", open_bank_mask, 8'h00);
                wait_until(c0 + 70);
                check("t4_ready_in_ref", req_ready, 0);
                wait_until(c0 + 71);
                check("t4_ready_after_ref", req_ready, 1);

                // Second expiry (c0+127) lands in RD_WAIT; max row/col address.
                wait_until(c0 + 123);
                do_req(1'b0, 3'd3, 7'd127, 3'd7, 8'h00, 8'hC3, t);
                check("t5_accept_cycle", t, c0 + 123);
                push_cmd(t + 1, ACT, 3'd3, 7'd127, 3'd0, 8'h00);
                push_cmd(t + 3, RD, 3'd3, 7'd0, 3'd7, 8'h00);
                push_rsp(t + 6, 8'hC3);
                push_cmd(c0 + 130, PREA, 3'd0, 7'd0, 3'd0, 8'h00);
                push_cmd(c0 + 132, REF, 3'd0, 7'd0, 3'd0, 8'h00);
                do_req(1'b0, 3'd3, 7'd127, 3'd0, 8'h00, 8'h81, t);
                check("t5_held_accept_cycle", t, c0 + 136);
                push_cmd(t + 1, ACT, 3'd3, 7'd127, 3'd0, 8'h00);
                push_cmd(t + 3, RD, 3'd3, 7'd0, 3'd0, 8'h00);
                push_rsp(t + 6, 8'h81);

                // Reset during the ACT wait drops the request.
                do_req(1'b0, 3'd1, 7'd3, 3'd2, 8'h00, 8'h77, t);
                push_cmd(t + 1, ACT, 3'd1, 7'd3, 3'd0, 8'h00);
                wait_until(t + 2);
                rst_b = 1'b0;
                #1;
                check("t6_reset_cmd", cmd, 0);
                check("t6_reset_mask", open_bank_mask, 0);
                check("t6_reset_ready", req_ready, 0);
                check("t6_pending_cmds", exp_cmd_q.size(), 0);
                rd_data_q.delete();
                repeat (3) @(negedge clk);
                rst_b = 1'b1;
                c1 = cyc;
                do_req(1'b0, 3'd1, 7'd3, 3'd2, 8'h00, 8'h96, t);
                check("t6_accept_cycle", t, c1 + 1);
                push_cmd(t + 1, ACT, 3'd1, 7'd3, 3'd0, 8'h00);
                push_cmd(t + 3, RD, 3'd1, 7'd0, 3'd2, 8'h00);
                push_rsp(t + 6, 8'h96);
                wait_until(t + 9);
                check("t6_mask", open_bank_mask, 8'h02);
                check("left_cmds", exp_cmd_q.size(), 0);
                check("left_rsps", exp_rsp_q.size(), 0);
            end
        join_any

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
